// File: rtl/systolic_pkg.sv
// Shared sizes and types for the 4x4 systolic multiplier and its stream adapter.
package systolic_pkg;
  localparam int N        = 4;
  localparam int DATA_W   = 8;
  localparam int ACC_W    = 16;
  localparam int WAIT_MAX = 31;
  localparam int WD_W     = $clog2(WAIT_MAX + 1);

  typedef logic [N-1:0][N-1:0][DATA_W-1:0] matA_t;
  typedef logic [N-1:0][N-1:0][ACC_W-1:0]  matC_t;

  typedef enum logic [2:0] {
    ST_LOAD_A = 3'd0,
    ST_LOAD_B = 3'd1,
    ST_START  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_DRAIN  = 3'd4
  } sa_state_t;
endpackage

// File: rtl/systolic_stream_adapter_if.sv
// Bundle between the stream fabric / array top and the systolic stream adapter.
interface systolic_stream_adapter_if;
  import systolic_pkg::*;

  // Handshakes: a stream beat transfers on a clock edge where valid & ready are
  // both high; valid holds data stable until accepted, ready may change freely.
  logic              i_clear;
  logic [DATA_W-1:0] i_sData;
  logic              i_sValid;
  logic              o_sReady;
  matA_t             o_a;
  matA_t             o_b;
  logic              o_validInput;
  matC_t             i_c;
  logic              i_validResult;
  logic [ACC_W-1:0]  o_mData;
  logic              o_mValid;
  logic              i_mReady;
  logic              o_mLast;
  logic              o_busy;
  logic              o_timeout;
  sa_state_t         o_state;

  modport slave (
    input  i_clear, i_sData, i_sValid, i_c, i_validResult, i_mReady,
    output o_sReady, o_a, o_b, o_validInput, o_mData, o_mValid, o_mLast,
           o_busy, o_timeout, o_state
  );

  modport master (
    output i_clear, i_sData, i_sValid, i_c, i_validResult, i_mReady,
    input  o_sReady, o_a, o_b, o_validInput, o_mData, o_mValid, o_mLast,
           o_busy, o_timeout, o_state
  );
endinterface

// File: rtl/sa_result_drain.sv
// Captures the 4x4 result matrix and serializes it row-major as a valid/ready stream.
module sa_result_drain
  import systolic_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_arst,
  input  logic             i_clear,
  input  logic             i_capture,
  input  matC_t            i_c,
  input  logic             i_mReady,
  output logic [ACC_W-1:0] o_mData,
  output logic             o_mValid,
  output logic             o_mLast,
  output logic             o_done
);
  matC_t      r_c;
  logic [3:0] r_j;
  logic       r_valid;
  logic       w_fire;

  assign w_fire = r_valid & i_mReady;

  // Clear drops valid without touching the captured matrix.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      r_c     <= '0;
      r_j     <= '0;
      r_valid <= 1'b0;
    end else if (i_clear) begin
      r_j     <= '0;
      r_valid <= 1'b0;
    end else if (i_capture) begin
      r_c     <= i_c;
      r_j     <= '0;
      r_valid <= 1'b1;
    end else if (w_fire) begin
      r_j <= r_j + 4'd1;
      if (r_j == 4'd15) r_valid <= 1'b0;
    end
  end

  assign o_mData  = r_c[r_j[3:2]][r_j[1:0]];
  assign o_mValid = r_valid;
  assign o_mLast  = r_valid & (r_j == 4'd15);
  assign o_done   = w_fire & (r_j == 4'd15);
endmodule

// File: rtl/systolic_stream_adapter.sv
// Stream front/back end for the 4x4 systolic array: loads A and B, starts the job, drains C.
module systolic_stream_adapter
  import systolic_pkg::*;
(
  input logic                      i_clk,
  input logic                      i_arst,
  systolic_stream_adapter_if.slave io_bus
);
  sa_state_t       r_state;
  sa_state_t       w_next;
  logic [3:0]      r_k;
  logic [WD_W-1:0] r_wd;
  matA_t           r_a;
  matA_t           r_b;
  logic            r_timeout;
  logic            w_load;
  logic            w_s_fire;
  logic            w_capture;
  logic            w_expire;
  logic            w_drain_done;
  logic            w_sready;
  logic            w_valid_input;
  logic            w_busy;

  assign w_load    = (r_state == ST_LOAD_A) || (r_state == ST_LOAD_B);
  assign w_s_fire  = w_load & io_bus.i_sValid;
  assign w_capture = (r_state == ST_WAIT) & io_bus.i_validResult & ~io_bus.i_clear;
  // A result arriving on the last watchdog cycle still wins over expiry.
  assign w_expire  = (r_state == ST_WAIT) & ~io_bus.i_validResult &
                     (r_wd == WD_W'(WAIT_MAX));

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) r_state <= ST_LOAD_A;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (io_bus.i_clear) begin
      w_next = ST_LOAD_A;
    end else begin
      case (r_state)
        ST_LOAD_A: if (w_s_fire && r_k == 4'd15) w_next = ST_LOAD_B;
        ST_LOAD_B: if (w_s_fire && r_k == 4'd15) w_next = ST_START;
        ST_START:  w_next = ST_WAIT;
        ST_WAIT: begin
          if (io_bus.i_validResult) w_next = ST_DRAIN;
          else if (w_expire)        w_next = ST_LOAD_A;
        end
        ST_DRAIN:  if (w_drain_done) w_next = ST_LOAD_A;
        default:   w_next = ST_LOAD_A;
      endcase
    end
  end

  always_comb begin
    w_sready      = 1'b0;
    w_valid_input = 1'b0;
    w_busy        = 1'b1;
    case (r_state)
      ST_LOAD_A: begin w_sready = 1'b1; w_busy = 1'b0; end
      ST_LOAD_B: w_sready = 1'b1;
      ST_START:  w_valid_input = 1'b1;
      default:   ;
    endcase
  end

  // Element loader: row-major byte index shared by A and B.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      r_k <= '0;
      r_a <= '0;
      r_b <= '0;
    end else if (io_bus.i_clear) begin
      r_k <= '0;
    end else if (w_s_fire) begin
      if (r_state == ST_LOAD_A) r_a[r_k[3:2]][r_k[1:0]] <= io_bus.i_sData;
      else                      r_b[r_k[3:2]][r_k[1:0]] <= io_bus.i_sData;
      r_k <= r_k + 4'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      r_wd      <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= ~io_bus.i_clear & w_expire;
      if (io_bus.i_clear || r_state != ST_WAIT) r_wd <= '0;
      else if (r_wd != WD_W'(WAIT_MAX))         r_wd <= r_wd + 1'b1;
    end
  end

  sa_result_drain u_drain (
    .i_clk     (i_clk),
    .i_arst    (i_arst),
    .i_clear   (io_bus.i_clear),
    .i_capture (w_capture),
    .i_c       (io_bus.i_c),
    .i_mReady  (io_bus.i_mReady),
    .o_mData   (io_bus.o_mData),
    .o_mValid  (io_bus.o_mValid),
    .o_mLast   (io_bus.o_mLast),
    .o_done    (w_drain_done)
  );

  assign io_bus.o_sReady     = w_sready;
  assign io_bus.o_validInput = w_valid_input;
  assign io_bus.o_busy       = w_busy;
  assign io_bus.o_timeout    = r_timeout;
  assign io_bus.o_a          = r_a;
  assign io_bus.o_b          = r_b;
  assign io_bus.o_state      = r_state;
endmodule

// File: tb/tb_systolic_stream_adapter.sv
// Directed bench for systolic_stream_adapter: load, start, result capture, drain, watchdog, clear, reset.
module tb_systolic_stream_adapter;
  import systolic_pkg::*;

  logic i_clk;
  logic i_arst;
  int   total = 0;
  int   bad = 0;
  int   vi_count = 0;
  int   vi_base = 0;

  matA_t m_ident;
  matA_t m_bseq;
  matA_t m_two;

  systolic_stream_adapter_if bus ();

  systolic_stream_adapter dut (
    .i_clk  (i_clk),
    .i_arst (i_arst),
    .io_bus (bus)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  always @(negedge i_clk) if (bus.o_validInput === 1'b1) vi_count++;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  function automatic matC_t matmul(input matA_t a, input matA_t b);
    matC_t c;
    c = '0;
    for (int r = 0; r < N; r++)
      for (int cc = 0; cc < N; cc++)
        for (int k = 0; k < N; k++)
          c[r][cc] = c[r][cc] + ACC_W'(a[r][k]) * ACC_W'(b[k][cc]);
    return c;
  endfunction

  task automatic load_job(input matA_t a, input matA_t b, input bit gaps, input bit stray);
    vi_base = vi_count;
    for (int m = 0; m < 2; m++) begin
      for (int k = 0; k < 16; k++) begin
        if (gaps && (k % 3 == 1)) begin
          bus.i_sValid = 1'b0;
          step();
        end
        bus.i_sValid = 1'b1;
        bus.i_sData  = (m == 0) ? a[k/4][k%4] : b[k/4][k%4];
        if (stray && m == 1 && k == 5) begin
          bus.i_validResult = 1'b1;
          bus.i_c = {16{16'hdead}};
        end
        total++;
        if (bus.o_sReady !== 1'b1) begin
          bad++;
          $display("FAIL load_ready m=%0d k=%0d got=%b exp=1", m, k, bus.o_sReady);
        end
        step();
        if (stray && m == 1 && k == 5) begin
          bus.i_validResult = 1'b0;
          total++;
          if (bus.o_state !== ST_LOAD_B || bus.o_busy !== 1'b1) begin
            bad++;
            $display("FAIL stray_result got state=%0d busy=%b exp state=%0d busy=1",
                     bus.o_state, bus.o_busy, ST_LOAD_B);
          end
        end
      end
    end
    bus.i_sValid = 1'b0;
    total++;
    if (bus.o_state !== ST_START || bus.o_validInput !== 1'b1 || bus.o_sReady !== 1'b0) begin
      bad++;
      $display("FAIL start_cycle got state=%0d vi=%b sready=%b exp state=%0d vi=1 sready=0",
               bus.o_state, bus.o_validInput, bus.o_sReady, ST_START);
    end
    total++;
    if (bus.o_a !== a) begin
      bad++;
      $display("FAIL matrix_a got=%h exp=%h", bus.o_a, a);
    end
    total++;
    if (bus.o_b !== b) begin
      bad++;
      $display("FAIL matrix_b got=%h exp=%h", bus.o_b, b);
    end
  endtask

  task automatic respond(input matC_t c, input int delay);
    step();
    total++;
    if (bus.o_state !== ST_WAIT || bus.o_validInput !== 1'b0 || vi_count != vi_base + 1) begin
      bad++;
      $display("FAIL wait_entry got state=%0d vi=%b pulses=%0d exp state=%0d vi=0 pulses=1",
               bus.o_state, bus.o_validInput, vi_count - vi_base, ST_WAIT);
    end
    for (int i = 0; i < delay; i++) step();
    bus.i_validResult = 1'b1;
    bus.i_c = c;
    step();
    bus.i_validResult = 1'b0;
    total++;
    if (bus.o_state !== ST_DRAIN || bus.o_mValid !== 1'b1 || bus.o_timeout !== 1'b0) begin
      bad++;
      $display("FAIL capture got state=%0d mvalid=%b timeout=%b exp state=%0d mvalid=1 timeout=0",
               bus.o_state, bus.o_mValid, bus.o_timeout, ST_DRAIN);
    end
  endtask

  task automatic drain(input int mult, input bit toggle, input int clear_at);
    int   idx;
    int   cyc;
    logic rdy;
    logic [ACC_W-1:0] exp_d;
    idx = 0;
    cyc = 0;
    while (idx < 16 && cyc < 200) begin
      rdy   = toggle ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      exp_d = ACC_W'(mult * idx);
      total++;
      if (bus.o_mValid !== 1'b1 || bus.o_mData !== exp_d || bus.o_mLast !== (idx == 15)) begin
        bad++;
        $display("FAIL drain_beat j=%0d got valid=%b data=%0d last=%b exp valid=1 data=%0d last=%b",
                 idx, bus.o_mValid, bus.o_mData, bus.o_mLast, exp_d, (idx == 15));
      end
      if (idx == clear_at) begin
        bus.i_clear  = 1'b1;
        bus.i_mReady = 1'b0;
        step();
        bus.i_clear = 1'b0;
        total++;
        if (bus.o_mValid !== 1'b0 || bus.o_state !== ST_LOAD_A || bus.o_busy !== 1'b0) begin
          bad++;
          $display("FAIL clear_drain got mvalid=%b state=%0d busy=%b exp mvalid=0 state=%0d busy=0",
                   bus.o_mValid, bus.o_state, bus.o_busy, ST_LOAD_A);
        end
        return;
      end
      bus.i_mReady = rdy;
      if (rdy) idx++;
      step();
      cyc++;
    end
    bus.i_mReady = 1'b0;
    total++;
    if (idx != 16) begin
      bad++;
      $display("FAIL drain_budget got beats=%0d exp=16", idx);
    end
    total++;
    if (bus.o_mValid !== 1'b0 || bus.o_state !== ST_LOAD_A || bus.o_busy !== 1'b0 ||
        vi_count != vi_base + 1) begin
      bad++;
      $display("FAIL drain_end got mvalid=%b state=%0d busy=%b pulses=%0d exp mvalid=0 state=%0d busy=0 pulses=1",
               bus.o_mValid, bus.o_state, bus.o_busy, vi_count - vi_base, ST_LOAD_A);
    end
  endtask

  task automatic test_reset();
    i_arst = 1'b1;
    bus.i_clear = 1'b0;
    bus.i_sData = '0;
    bus.i_sValid = 1'b0;
    bus.i_c = '0;
    bus.i_validResult = 1'b0;
    bus.i_mReady = 1'b0;
    step();
    step();
    i_arst = 1'b0;
    step();
    total++;
    if ({bus.o_sReady, bus.o_validInput, bus.o_mValid, bus.o_mLast, bus.o_busy, bus.o_timeout} !== 6'b100000 ||
        bus.o_state !== ST_LOAD_A) begin
      bad++;
      $display("FAIL reset_ctrl got=%b state=%0d exp=100000 state=%0d",
               {bus.o_sReady, bus.o_validInput, bus.o_mValid, bus.o_mLast, bus.o_busy, bus.o_timeout},
               bus.o_state, ST_LOAD_A);
    end
    total++;
    if (bus.o_a !== '0 || bus.o_b !== '0) begin
      bad++;
      $display("FAIL reset_mats got a=%h b=%h exp 0", bus.o_a, bus.o_b);
    end
  endtask

  task automatic test_basic();
    load_job(m_ident, m_bseq, 1'b0, 1'b0);
    respond(matmul(m_ident, m_bseq), 4);
    drain(1, 1'b0, -1);
  endtask

  task automatic test_stalls();
    load_job(m_ident, m_bseq, 1'b1, 1'b0);
    respond(matmul(m_ident, m_bseq), 7);
    drain(1, 1'b1, -1);
  endtask

  task automatic test_timeout();
    load_job(m_ident, m_bseq, 1'b0, 1'b0);
    step();
    for (int c = 0; c <= 36; c++) begin
      total++;
      if (bus.o_timeout !== (c == 32) || bus.o_mValid !== 1'b0) begin
        bad++;
        $display("FAIL timeout_pulse c=%0d got timeout=%b mvalid=%b exp timeout=%b mvalid=0",
                 c, bus.o_timeout, bus.o_mValid, (c == 32));
      end
      if (c == 32 || c == 33) begin
        total++;
        if (bus.o_sReady !== 1'b1 || bus.o_state !== ST_LOAD_A) begin
          bad++;
          $display("FAIL timeout_return c=%0d got sready=%b state=%0d exp sready=1 state=%0d",
                   c, bus.o_sReady, bus.o_state, ST_LOAD_A);
        end
      end
      step();
    end
  endtask

  task automatic test_result_at_expiry();
    load_job(m_ident, m_bseq, 1'b0, 1'b0);
    respond(matmul(m_ident, m_bseq), 31);
    drain(1, 1'b0, -1);
  endtask

  task automatic test_stray_and_clear();
    load_job(m_ident, m_bseq, 1'b0, 1'b1);
    respond(matmul(m_ident, m_bseq), 3);
    drain(1, 1'b0, 7);
    load_job(m_two, m_bseq, 1'b0, 1'b0);
    respond(matmul(m_two, m_bseq), 2);
    drain(2, 1'b1, -1);
  endtask

  task automatic test_async_reset();
    load_job(m_two, m_bseq, 1'b0, 1'b0);
    step();
    step();
    step();
    #2;
    i_arst = 1'b1;
    #1;
    total++;
    if ({bus.o_sReady, bus.o_validInput, bus.o_mValid, bus.o_mLast, bus.o_busy, bus.o_timeout} !== 6'b100000 ||
        bus.o_state !== ST_LOAD_A || bus.o_a !== '0 || bus.o_b !== '0) begin
      bad++;
      $display("FAIL async_reset got ctrl=%b state=%0d a=%h b=%h exp ctrl=100000 state=%0d a=0 b=0",
               {bus.o_sReady, bus.o_validInput, bus.o_mValid, bus.o_mLast, bus.o_busy, bus.o_timeout},
               bus.o_state, bus.o_a, bus.o_b, ST_LOAD_A);
    end
    step();
    i_arst = 1'b0;
    step();
    load_job(m_ident, m_bseq, 1'b0, 1'b0);
    respond(matmul(m_ident, m_bseq), 5);
    drain(1, 1'b1, -1);
  endtask

  initial begin
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        m_ident[r][c] = (r == c) ? 8'd1 : 8'd0;
        m_two[r][c]   = (r == c) ? 8'd2 : 8'd0;
        m_bseq[r][c]  = 8'(r * 4 + c);
      end
    test_reset();
    test_basic();
    test_stalls();
    test_timeout();
    test_result_at_expiry();
    test_stray_and_clear();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
